// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the parametrised register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned ZERO_REG         = 0;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Reset-time clear sequencer: walks every entry once after reset, zeroing it, then goes READY.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset itself counts as busy so nothing reads or writes the array across the restart edge.
  assign busy_o     = rst_i | (state_q == CLEAR);
  assign clr_we_o   = ~rst_i & (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with r0 hardwired to zero and a post-reset clear.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              busy
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic [DATA_W-1:0] rd1, rd2;

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .clk_i      (clock),
    .rst_i      (reset),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteReg;
    mem_wdata = WriteData;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (!busy && RegWrite && (WriteReg != ADDR_W'(ZERO_REG))) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = RegWrite && (WriteReg != ADDR_W'(ZERO_REG));
`endif

  always_comb begin
    rd1 = mem_q[Read1];
    rd2 = mem_q[Read2];
`ifdef REGFILE_BYPASS_EN
    if (fwd_en && (WriteReg == Read1)) rd1 = WriteData;
    if (fwd_en && (WriteReg == Read2)) rd2 = WriteData;
`endif
  end

  // Masking covers r0 and the whole clear window, so stale contents never leak out.
  assign Data1 = (busy || (Read1 == ADDR_W'(ZERO_REG))) ? '0 : rd1;
  assign Data2 = (busy || (Read2 == ADDR_W'(ZERO_REG))) ? '0 : rd2;

endmodule
